// File: rtl/sample_strobe_gen.sv
// Clock-enable strobe generator: a 0..R-1 counter decoded into per-channel strobes,
// with ratio changes deferred to the period boundary. Option macro: SAMPLE_STROBE_HALT_EN.
module sample_strobe_gen #(
  parameter int CNT_W  = 8,
  parameter int NUM_CH = 2
) (
  input  logic              clk_in,
  input  logic              rst,
  input  logic              enable,
  input  logic              div_load,
  input  logic [CNT_W-1:0]  div_value,
  output logic              div_ack,
  output logic [NUM_CH-1:0] strobe,
  output logic [CNT_W-1:0]  cur_div,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    PEND = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] cur_div_q, cur_div_d;
  logic [CNT_W-1:0] pend_q, pend_d;
  logic             ack_q, ack_d;
  logic             wrap;
  logic             apply;
  logic [CNT_W-1:0] apply_val;
`ifdef SAMPLE_STROBE_HALT_EN
  logic             halt_q, halt_d;
`endif

  always_ff @(posedge clk_in) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      cur_div_q <= CNT_W'(1);
      pend_q    <= '0;
      ack_q     <= 1'b0;
`ifdef SAMPLE_STROBE_HALT_EN
      halt_q    <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      cur_div_q <= cur_div_d;
      pend_q    <= pend_d;
      ack_q     <= ack_d;
`ifdef SAMPLE_STROBE_HALT_EN
      halt_q    <= halt_d;
`endif
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    cur_div_d = cur_div_q;
    pend_d    = pend_q;
    ack_d     = 1'b0;
`ifdef SAMPLE_STROBE_HALT_EN
    halt_d    = halt_q;
`endif
    apply     = 1'b0;
    apply_val = div_value;
    // cur_div_q is never 0, so R-1 cannot underflow
    wrap      = (cnt_q == cur_div_q - CNT_W'(1));

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (div_load) begin
          apply = 1'b1;
`ifdef SAMPLE_STROBE_HALT_EN
        end else if (enable && !halt_q) begin
`else
        end else if (enable) begin
`endif
          state_d = RUN;
        end
      end
      default: begin
        if (wrap) begin
          cnt_d   = '0;
          state_d = enable ? RUN : IDLE;
          if (div_load) begin
            apply = 1'b1;
          end else if (state_q == PEND) begin
            apply     = 1'b1;
            apply_val = pend_q;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
          if (div_load) begin
            pend_d  = div_value;
            state_d = PEND;
          end
        end
      end
    endcase

    // Applying a ratio always acknowledges; a zero ratio is halt or pass-through
    if (apply) begin
      ack_d  = 1'b1;
      pend_d = '0;
`ifdef SAMPLE_STROBE_HALT_EN
      if (apply_val == '0) begin
        halt_d  = 1'b1;
        state_d = IDLE;
      end else begin
        halt_d    = 1'b0;
        cur_div_d = apply_val;
        if (state_q == IDLE && enable) state_d = RUN;
      end
`else
      cur_div_d = (apply_val == '0) ? CNT_W'(1) : apply_val;
      if (state_q == IDLE && enable) state_d = RUN;
`endif
    end
  end

  assign busy    = (state_q != IDLE);
  assign div_ack = ack_q;
  assign cur_div = cur_div_q;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_strobe
      assign strobe[gi] = busy && (cnt_q == CNT_W'(gi));
    end
  endgenerate

endmodule

// File: tb/tb_sample_strobe_gen.sv
// Directed bench for sample_strobe_gen: inputs change 1 ns after each rising edge,
// and the registered outputs are checked at that same point.
module tb_sample_strobe_gen;

  logic       clk_in = 1'b0;
  logic       rst = 1'b1;
  logic       enable = 1'b0;
  logic       div_load = 1'b0;
  logic [7:0] div_value = 8'd0;
  logic       div_ack;
  logic [1:0] strobe;
  logic [7:0] cur_div;
  logic       busy;

  int n_vec = 0;
  int n_err = 0;

  sample_strobe_gen #(.CNT_W(8), .NUM_CH(2)) dut (
    .clk_in   (clk_in),
    .rst      (rst),
    .enable   (enable),
    .div_load (div_load),
    .div_value(div_value),
    .div_ack  (div_ack),
    .strobe   (strobe),
    .cur_div  (cur_div),
    .busy     (busy)
  );

  always #5 clk_in = ~clk_in;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic check_out(input string tag, input logic [1:0] s, input logic b,
                           input logic a, input logic [7:0] c);
    check_val({tag, ".strobe"}, 32'(strobe), 32'(s));
    check_val({tag, ".busy"}, 32'(busy), 32'(b));
    check_val({tag, ".ack"}, 32'(div_ack), 32'(a));
    check_val({tag, ".cur"}, 32'(cur_div), 32'(c));
    $display("t=%0t %s strobe=%b busy=%b ack=%b cur_div=%0d", $time, tag, strobe, busy, div_ack, cur_div);
  endtask

  initial begin
    // Reset state and default R=1 pass-through
    tick();
    check_out("reset", 2'b00, 1'b0, 1'b0, 8'd1);
    rst = 1'b0; enable = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_out($sformatf("r1_c%0d", i), 2'b01, 1'b1, 1'b0, 8'd1);
    end
    enable = 1'b0;
    tick();
    check_out("r1_stop", 2'b00, 1'b0, 1'b0, 8'd1);

    // Load R=4 in IDLE, then run
    div_load = 1'b1; div_value = 8'd4;
    tick();
    check_out("ld4_idle", 2'b00, 1'b0, 1'b1, 8'd4);
    div_load = 1'b0; enable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      check_out($sformatf("r4_c%0d", i),
                (i % 4 == 0) ? 2'b01 : ((i % 4 == 1) ? 2'b10 : 2'b00), 1'b1, 1'b0, 8'd4);
    end

    // At cnt=1 load 7, then overwrite with 3 while pending: one ack, R=3
    div_load = 1'b1; div_value = 8'd7;
    tick();
    check_out("pend_c2", 2'b00, 1'b1, 1'b0, 8'd4);
    div_value = 8'd3;
    tick();
    check_out("pend_c3", 2'b00, 1'b1, 1'b0, 8'd4);
    div_load = 1'b0;
    tick();
    check_out("r3_c0", 2'b01, 1'b1, 1'b1, 8'd3);
    tick();
    check_out("r3_c1", 2'b10, 1'b1, 1'b0, 8'd3);
    tick();
    check_out("r3_c2", 2'b00, 1'b1, 1'b0, 8'd3);

    // Load coincident with the wrap edge takes effect at that edge
    div_load = 1'b1; div_value = 8'd5;
    tick();
    check_out("r5_c0", 2'b01, 1'b1, 1'b1, 8'd5);
    div_load = 1'b0;
    tick();
    check_out("r5_c1", 2'b10, 1'b1, 1'b0, 8'd5);
    tick();
    check_out("r5_c2", 2'b00, 1'b1, 1'b0, 8'd5);

    // Drop enable at cnt=2: period completes, then idle
    enable = 1'b0;
    tick();
    check_out("r5_c3", 2'b00, 1'b1, 1'b0, 8'd5);
    tick();
    check_out("r5_c4", 2'b00, 1'b1, 1'b0, 8'd5);
    tick();
    check_out("r5_idle", 2'b00, 1'b0, 1'b0, 8'd5);
    tick();
    check_out("r5_idle2", 2'b00, 1'b0, 1'b0, 8'd5);

    // R=6 with a pending change, then reset discards it without ack
    div_load = 1'b1; div_value = 8'd6;
    tick();
    check_out("ld6", 2'b00, 1'b0, 1'b1, 8'd6);
    div_load = 1'b0; enable = 1'b1;
    tick();
    check_out("r6_c0", 2'b01, 1'b1, 1'b0, 8'd6);
    tick();
    check_out("r6_c1", 2'b10, 1'b1, 1'b0, 8'd6);
    div_load = 1'b1; div_value = 8'd2;
    tick();
    check_out("r6_pend", 2'b00, 1'b1, 1'b0, 8'd6);
    div_load = 1'b0; rst = 1'b1;
    tick();
    check_out("r6_rst", 2'b00, 1'b0, 1'b0, 8'd1);
    rst = 1'b0; enable = 1'b0;
    tick();
    check_out("r6_post", 2'b00, 1'b0, 1'b0, 8'd1);

    // Load 4 together with enable in IDLE, then load 0 while running
    div_load = 1'b1; div_value = 8'd4; enable = 1'b1;
    tick();
    check_out("z_c0", 2'b01, 1'b1, 1'b1, 8'd4);
    div_load = 1'b0;
    tick();
    check_out("z_c1", 2'b10, 1'b1, 1'b0, 8'd4);
    div_load = 1'b1; div_value = 8'd0;
    tick();
    check_out("z_c2", 2'b00, 1'b1, 1'b0, 8'd4);
    div_load = 1'b0;
    tick();
    check_out("z_c3", 2'b00, 1'b1, 1'b0, 8'd4);
`ifdef SAMPLE_STROBE_HALT_EN
    tick();
    check_out("z_halt", 2'b00, 1'b0, 1'b1, 8'd4);
    tick();
    check_out("z_halt2", 2'b00, 1'b0, 1'b0, 8'd4);
    tick();
    check_out("z_halt3", 2'b00, 1'b0, 1'b0, 8'd4);
    div_load = 1'b1; div_value = 8'd2;
    tick();
    check_out("z_resume", 2'b01, 1'b1, 1'b1, 8'd2);
    div_load = 1'b0;
    tick();
    check_out("z_resume1", 2'b10, 1'b1, 1'b0, 8'd2);
`else
    tick();
    check_out("z_pass", 2'b01, 1'b1, 1'b1, 8'd1);
    tick();
    check_out("z_pass1", 2'b01, 1'b1, 1'b0, 8'd1);
    tick();
    check_out("z_pass2", 2'b01, 1'b1, 1'b0, 8'd1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/sample_strobe_gen.md
SAMPLE_STROBE_GEN -- requirements
Module: sample_strobe_gen

Interface
REQ-001 SHALL have parameter CNT_W, default 8, giving the divide-ratio and counter width in bits.
REQ-002 SHALL have parameter NUM_CH, default 2, giving the number of strobe channels (1..2^CNT_W-1).
REQ-003 SHALL have port clk_in, input, 1, the single clock; all logic is on its rising edge.
REQ-004 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port enable, input, 1: run request.
REQ-006 SHALL have port div_load, input, 1: single-cycle request to load div_value.
REQ-007 SHALL have port div_value, input, CNT_W: requested divide ratio R.
REQ-008 SHALL have port div_ack, output, 1: one-cycle pulse when a loaded ratio takes effect.
REQ-009 SHALL have port strobe, output, NUM_CH: per-channel clock-enable strobes.
REQ-010 SHALL have port cur_div, output, CNT_W: currently active ratio.
REQ-011 SHALL have port busy, output, 1: high whenever the state is not IDLE.

Function
REQ-012 SHALL generate clock-enable strobes only, never a derived or gated clock; consumers (ramfill, ram) run on clk_in qualified by strobe.
REQ-013 SHALL implement the states IDLE, RUN and PEND (RUN with a pending ratio change).
REQ-014 SHALL keep counter cnt, counting 0..R-1 while in RUN or PEND, wrapping to 0 after R-1 (the wrap edge).
REQ-015 SHALL drive strobe[k] = busy AND (cnt == k), decoded combinationally from registers; channels with k >= R never assert.
REQ-016 SHALL therefore, with R=1, assert strobe[0] every cycle, which is the pass-through mode.
REQ-017 SHALL, in IDLE with enable=1 at edge e, enter RUN with cnt=0 after e, so that strobe[0] is high in the cycle following e.
REQ-018 SHALL, when enable=0 in RUN/PEND, complete the current period and enter IDLE at the wrap edge; no partial period.
REQ-019 SHALL, on div_load in IDLE, set cur_div on the next edge and pulse div_ack in the following cycle.
REQ-020 SHALL, on div_load in RUN, latch div_value into a pending register, enter PEND, apply it at the next wrap edge (cnt restarts at 0 with the new R), return to RUN, and pulse div_ack in the cycle after that edge.
REQ-021 SHALL, on div_load coincident with a wrap edge, apply div_value at that same edge.
REQ-022 SHALL, on div_load while in PEND, overwrite the pending value; only one div_ack is issued, for the last value.
REQ-023 SHALL, on div_load and enable together in IDLE, enter RUN directly with the new R.
REQ-024 SHALL, when enable=0 and a pending value exist at the wrap edge, apply the value, enter IDLE and pulse div_ack.
REQ-025 SHALL treat R as unsigned with maximum 2^CNT_W-1; cnt SHALL never exceed R-1.

Reset
REQ-026 SHALL, when rst is sampled high, force state=IDLE, cnt=0, cur_div=1, pending cleared, strobe=0, div_ack=0, busy=0 on that edge.
REQ-027 SHALL give rst priority over enable and div_load in the same cycle; a mid-period or pending load is discarded without div_ack.

Configuration
REQ-028 SHALL use the macro SAMPLE_STROBE_HALT_EN.
REQ-029 SHALL, with SAMPLE_STROBE_HALT_EN defined, treat div_value=0 as a halt request: applied per REQ-019/REQ-020, it enters IDLE regardless of enable, pulses div_ack, and leaves cur_div unchanged; enable is ignored until a nonzero ratio is loaded.
REQ-030 SHALL, with SAMPLE_STROBE_HALT_EN undefined, treat div_value=0 as R=1, with cur_div reading 1.

Verification
REQ-031 SHALL cover: rst, then enable=1 with default R=1 -> strobe[0] high every cycle, strobe[1]=0, cur_div=1.
REQ-032 SHALL cover: div_load with 4 in IDLE, then enable -> strobe[0] on cycles 0,4,8 and strobe[1] on cycles 1,5,9; div_ack one pulse.
REQ-033 SHALL cover: R=4 running, div_load with 3 at cnt=1 -> the old period completes (cnt 2,3), then a period of 3 cycles, with div_ack once after the wrap.
REQ-034 SHALL cover: R=5, enable dropped at cnt=2 -> strobes continue to cnt=4, then busy=0 and no further strobes.
REQ-035 SHALL cover: R=6 in PEND, rst asserted -> all outputs 0, cur_div=1, no div_ack.
REQ-036 SHALL cover: div_value=0 loaded while running -> halt to IDLE with div_ack (macro defined), or R=1 pass-through (macro undefined).
